// File: rtl/frame_buffer.sv
// Double-buffered 128x64 monochrome frame store feeding the LCD driver.
// Pixel read-modify-write and clear target the back buffer; swaps happen at frame end.
module frame_buffer #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 64,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          disp_addr_i,
    output logic [DATA_W-1:0]          disp_data_o,
    input  logic                       frame_done_i,
    input  logic                       px_valid_i,
    input  logic [$clog2(WIDTH)-1:0]   px_x_i,
    input  logic [$clog2(HEIGHT)-1:0]  px_y_i,
    input  logic                       px_val_i,
    output logic                       px_ready_o,
    input  logic                       clr_i,
    output logic                       busy_o,
    input  logic                       swap_req_i,
    output logic                       swap_pending_o,
    output logic                       front_sel_o
);

    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int DEPTH = WIDTH * HEIGHT / DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_CLR
    } state_t;

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        bit_q, bit_d;
    logic              val_q, val_d;
    logic              tgt_q, tgt_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic              front_q, front_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] disp_q, disp_d;

    logic              ready;
    logic              we;
    logic              wsel;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    assign ready          = (state_q == S_IDLE) && !pend_q;
    assign px_ready_o     = ready;
    assign busy_o         = (state_q != S_IDLE);
    assign swap_pending_o = pend_q;
    assign front_sel_o    = front_q;
    assign disp_data_o    = disp_q;

    always_comb begin
        disp_d = front_q ? mem1[disp_addr_i] : mem0[disp_addr_i];
    end

    // Swap tracking runs regardless of what the write engine is doing.
    always_comb begin
        front_d = front_q;
        pend_d  = pend_q;
        if (frame_done_i && (swap_req_i || pend_q)) begin
            front_d = ~front_q;
            pend_d  = 1'b0;
        end else if (swap_req_i) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        bit_d   = bit_q;
        val_d   = val_q;
        tgt_d   = tgt_q;
        rdat_d  = rdat_q;
        we      = 1'b0;
        wsel    = tgt_q;
        waddr   = addr_q;
        wdata   = rdat_q;
        unique case (state_q)
            S_IDLE: begin
                if (ready && clr_i) begin
                    cnt_d   = '0;
                    tgt_d   = ~front_q;
                    state_d = S_CLR;
                end else if (ready && px_valid_i) begin
                    addr_d  = {px_y_i[YW-1:3], px_x_i[XW-1:0]};
                    bit_d   = px_y_i[2:0];
                    val_d   = px_val_i;
                    tgt_d   = ~front_q;
                    rdat_d  = front_q ? mem0[addr_d] : mem1[addr_d];
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_WR;
            end
            S_WR: begin
                we           = 1'b1;
                wdata[bit_q] = val_q;
                state_d      = S_IDLE;
            end
            S_CLR: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = '0;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            bit_q   <= '0;
            val_q   <= 1'b0;
            tgt_q   <= 1'b0;
            rdat_q  <= '0;
            front_q <= 1'b0;
            pend_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            bit_q   <= bit_d;
            val_q   <= val_d;
            tgt_q   <= tgt_d;
            rdat_q  <= rdat_d;
            front_q <= front_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            if (wsel) begin
                mem1[waddr] <= wdata;
            end else begin
                mem0[waddr] <= wdata;
            end
        end
    end

endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
Double-buffered 128x64 monochrome frame store that sits directly upstream of the LCD Driver. It serves the Driver's byte-read port (addr/data, 1-cycle latency) from the front buffer. Game logic plots single pixels or clears the back buffer. A swap request flips front and back at the next Driver end-of-frame, so the display never tears.

Parameters:
WIDTH, 128, display columns (x range)
HEIGHT, 64, display rows (y range); HEIGHT/8 pages
ADDR_W, 10, byte address width per buffer (WIDTH*HEIGHT/8 = 1024)
DATA_W, 8, byte width (one page column, 8 vertical pixels)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
disp_addr_i  in  10  Driver read address {page[2:0], col[6:0]}
disp_data_o  out  8  front-buffer byte at disp_addr_i, registered
frame_done_i  in  1  one-cycle pulse from Driver: full frame transferred
px_valid_i  in  1  pixel write request
px_x_i  in  7  pixel column 0..127
px_y_i  in  6  pixel row 0..63
px_val_i  in  1  pixel value (1 = on)
px_ready_o  out  1  pixel/clear request accepted this cycle when high
clr_i  in  1  clear back buffer to 0x00 (accepted under same rule as px)
busy_o  out  1  write engine not idle
swap_req_i  in  1  request front/back swap
swap_pending_o  out  1  swap requested, waiting for frame_done_i
front_sel_o  out  1  index of buffer currently displayed

Behaviour:
- Storage: two 1024x8 arrays, buf[front_sel_o] is front, buf[~front_sel_o] is back. Memory contents are not reset.
- Pixel mapping: byte addr = {y[5:3], x[6:0]}, bit = y[2:0], LSB = top row of the page.
- Read port: disp_data_o <= front[disp_addr_i] every clock. Latency is 1 cycle. After a swap, the new front is used for reads from the first edge after front_sel_o changes.
- Reset (async) values: disp_data_o=0, px_ready_o=1, busy_o=0, swap_pending_o=0, front_sel_o=0, FSM=IDLE, clear counter=0.
- px_ready_o = (state==IDLE) && !swap_pending_o. busy_o = (state!=IDLE).
- FSM states:
  - IDLE: if ready && clr_i, zero the counter and go to CLR. Else if ready && px_valid_i, latch x/y/val, issue a back read at the byte address, and go to RD. clr_i beats px_valid_i in the same cycle; the pixel is dropped and not queued.
  - RD: back byte is available. Go to WR.
  - WR: write the byte with the target bit set or cleared per val; other 7 bits are unchanged. Go to IDLE. A pixel takes 3 cycles, IDLE to IDLE.
  - CLR: write 0x00 to back[counter] and increment. At counter==1023, write and go to IDLE. The clear takes 1024 cycles in CLR.
- Swap logic, independent of the FSM:
  - swap_req_i && frame_done_i in the same cycle: toggle front_sel_o at that edge; swap_pending_o stays 0.
  - swap_req_i alone: swap_pending_o <= 1.
  - frame_done_i && swap_pending_o: toggle front_sel_o and set swap_pending_o <= 0.
  - frame_done_i with no request: no effect.
  - swap_req_i while already pending: no effect.
- Swap while the engine is busy: the swap is still honoured at frame_done_i. The in-flight RMW or clear keeps its latched target buffer, captured at acceptance. Upstream must request a swap only when busy_o=0.
- Reset mid-operation: FSM returns to IDLE immediately. A partial clear or RMW is abandoned and the back-buffer contents are undefined.

Test Plan:
1. Reset, then clr_i for 1 cycle. busy_o is high for exactly 1024 cycles. Then swap_req_i and frame_done_i together, clr again, swap again. Reading addr 0..1023 returns 0x00 each, 1 cycle after each address.
2. After a clear, plot (x=5,y=10,val=1), then swap. Addr 133 ({3'd1,7'd5}) reads 0x04. Addrs 132 and 134 read 0x00.
3. Plot (5,11,1) then (5,10,1) then (5,10,0), then swap. Addr 133 reads 0x08, showing RMW preserves neighbouring bits. Each pixel takes 3 cycles, with px_ready_o low for 2 of them.
4. swap_req_i alone. swap_pending_o=1, front_sel_o unchanged, and px_ready_o=0 for 50 cycles. Pulse frame_done_i: front_sel_o toggles at that edge and swap_pending_o clears.
5. clr_i and px_valid_i asserted together in IDLE. CLR is entered and the pixel is not written: after the clear and a swap, the target byte reads 0x00.
6. Assert rst while the clear counter is at 500. busy_o=0, front_sel_o=0, swap_pending_o=0 and disp_data_o=0 without waiting for a clock edge. px_ready_o=1 after release.
